// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, global stall and a saturating count of hazard bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [31:0]       id_pc_i,
    input  logic [DATA_W-1:0] id_rdata1_i,
    input  logic [DATA_W-1:0] id_rdata2_i,
    input  logic [4:0]        id_raddr1_i,
    input  logic [4:0]        id_raddr2_i,
    input  logic              id_use1_i,
    input  logic              id_use2_i,
    input  logic [4:0]        id_waddr_i,
    input  logic              id_wreg_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic [4:0]        id_aluop_i,
    input  logic [DATA_W-1:0] id_imm_i,
    output logic              ex_valid_o,
    output logic              ex_wreg_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic [31:0]       ex_pc_o,
    output logic [DATA_W-1:0] ex_rdata1_o,
    output logic [DATA_W-1:0] ex_rdata2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [4:0]        ex_waddr_o,
    output logic [4:0]        ex_aluop_o,
    output logic              hazard_stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic src1_hit;
    logic src2_hit;
    logic hazard;
    logic bubble;

    // A load in EX cannot forward its data; a dependent instruction in ID must wait one cycle.
    always_comb begin
        src1_hit = id_use1_i && (id_raddr1_i == ex_waddr_o);
        src2_hit = id_use2_i && (id_raddr2_i == ex_waddr_o);
        hazard   = id_valid_i && ex_valid_o && ex_mem_read_o && ex_wreg_o &&
                   (ex_waddr_o != 5'd0) && (src1_hit || src2_hit);
        bubble   = flush_i || hazard;
    end

    assign hazard_stall_o = hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o     <= 1'b0;
            ex_wreg_o      <= 1'b0;
            ex_mem_read_o  <= 1'b0;
            ex_mem_write_o <= 1'b0;
            ex_pc_o        <= '0;
            ex_rdata1_o    <= '0;
            ex_rdata2_o    <= '0;
            ex_imm_o       <= '0;
            ex_waddr_o     <= '0;
            ex_aluop_o     <= '0;
        end else if (!stall_i) begin
            if (bubble) begin
                ex_valid_o     <= 1'b0;
                ex_wreg_o      <= 1'b0;
                ex_mem_read_o  <= 1'b0;
                ex_mem_write_o <= 1'b0;
                ex_pc_o        <= '0;
                ex_rdata1_o    <= '0;
                ex_rdata2_o    <= '0;
                ex_imm_o       <= '0;
                ex_waddr_o     <= '0;
                ex_aluop_o     <= '0;
            end else begin
                // Control side effects are suppressed for an empty slot; data passes through.
                ex_valid_o     <= id_valid_i;
                ex_wreg_o      <= id_valid_i && id_wreg_i;
                ex_mem_read_o  <= id_valid_i && id_mem_read_i;
                ex_mem_write_o <= id_valid_i && id_mem_write_i;
                ex_pc_o        <= id_pc_i;
                ex_rdata1_o    <= id_rdata1_i;
                ex_rdata2_o    <= id_rdata2_i;
                ex_imm_o       <= id_imm_i;
                ex_waddr_o     <= id_waddr_i;
                ex_aluop_o     <= id_aluop_i;
            end
        end
    end

    // Flush outranks the hazard, so a flushed hazard is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_o <= '0;
        end else if (!stall_i && !flush_i && hazard && (bubble_cnt_o != '1)) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage, checked against a
// transaction-level model of the EX register and bubble counter.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i, flush_i;
    logic          id_valid_i;
    logic [31:0]   id_pc_i;
    logic [DW-1:0] id_rdata1_i, id_rdata2_i, id_imm_i;
    logic [4:0]    id_raddr1_i, id_raddr2_i, id_waddr_i, id_aluop_i;
    logic          id_use1_i, id_use2_i, id_wreg_i, id_mem_read_i, id_mem_write_i;
    logic          ex_valid_o, ex_wreg_o, ex_mem_read_o, ex_mem_write_o;
    logic [31:0]   ex_pc_o;
    logic [DW-1:0] ex_rdata1_o, ex_rdata2_o, ex_imm_o;
    logic [4:0]    ex_waddr_o, ex_aluop_o;
    logic          hazard_stall_o;
    logic [CW-1:0] bubble_cnt_o;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i),
        .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i),
        .id_use1_i(id_use1_i), .id_use2_i(id_use2_i),
        .id_waddr_i(id_waddr_i), .id_wreg_i(id_wreg_i),
        .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .id_aluop_i(id_aluop_i), .id_imm_i(id_imm_i),
        .ex_valid_o(ex_valid_o), .ex_wreg_o(ex_wreg_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_pc_o(ex_pc_o), .ex_rdata1_o(ex_rdata1_o), .ex_rdata2_o(ex_rdata2_o),
        .ex_imm_o(ex_imm_o), .ex_waddr_o(ex_waddr_o), .ex_aluop_o(ex_aluop_o),
        .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, wreg, mem_read, mem_write;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  waddr, aluop;
    } ex_t;

    ex_t m;
    int  m_cnt;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // EX slot holding a load whose destination the ID instruction reads.
    function automatic logic model_hazard();
        logic reads_dest;
        reads_dest = (id_use1_i && id_raddr1_i == m.waddr) || (id_use2_i && id_raddr2_i == m.waddr);
        return id_valid_i && m.valid && m.mem_read && m.wreg && m.waddr != 0 && reads_dest;
    endfunction

    function automatic ex_t empty_slot();
        ex_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic ex_t captured();
        ex_t e;
        e.valid     = id_valid_i;
        e.wreg      = id_valid_i ? id_wreg_i : 1'b0;
        e.mem_read  = id_valid_i ? id_mem_read_i : 1'b0;
        e.mem_write = id_valid_i ? id_mem_write_i : 1'b0;
        e.pc = id_pc_i; e.rd1 = id_rdata1_i; e.rd2 = id_rdata2_i; e.imm = id_imm_i;
        e.waddr = id_waddr_i; e.aluop = id_aluop_i;
        return e;
    endfunction

    task automatic check_ex(input string tag);
        check({tag, ".valid"}, ex_valid_o, m.valid);
        check({tag, ".wreg"}, ex_wreg_o, m.wreg);
        check({tag, ".mrd"}, ex_mem_read_o, m.mem_read);
        check({tag, ".mwr"}, ex_mem_write_o, m.mem_write);
        check({tag, ".pc"}, ex_pc_o, m.pc);
        check({tag, ".rd1"}, ex_rdata1_o, m.rd1);
        check({tag, ".rd2"}, ex_rdata2_o, m.rd2);
        check({tag, ".imm"}, ex_imm_o, m.imm);
        check({tag, ".waddr"}, ex_waddr_o, m.waddr);
        check({tag, ".aluop"}, ex_aluop_o, m.aluop);
        check({tag, ".cnt"}, bubble_cnt_o, m_cnt);
        check({tag, ".haz"}, hazard_stall_o, model_hazard());
    endtask

    // Inputs are set 1 time unit after a rising edge; this advances one clock.
    task automatic step(input string tag);
        ex_t nxt;
        int  ncnt;
        #2;
        check({tag, ".haz_pre"}, hazard_stall_o, model_hazard());
        nxt  = m;
        ncnt = m_cnt;
        if (stall_i) begin
            nxt = m;
        end else if (flush_i) begin
            nxt = empty_slot();
        end else if (model_hazard()) begin
            nxt  = empty_slot();
            ncnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        end else begin
            nxt = captured();
        end
        @(posedge clk);
        #1;
        m     = nxt;
        m_cnt = ncnt;
        check_ex(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m     = empty_slot();
        m_cnt = 0;
        check_ex(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_id();
        id_valid_i = 0; id_pc_i = '0; id_rdata1_i = '0; id_rdata2_i = '0; id_imm_i = '0;
        id_raddr1_i = '0; id_raddr2_i = '0; id_use1_i = 0; id_use2_i = 0;
        id_waddr_i = '0; id_wreg_i = 0; id_mem_read_i = 0; id_mem_write_i = 0; id_aluop_i = '0;
    endtask

    task automatic set_load(input logic [4:0] dest);
        clear_id();
        id_valid_i = 1; id_wreg_i = 1; id_mem_read_i = 1; id_waddr_i = dest;
        id_pc_i = 32'h200; id_aluop_i = 5'd3;
    endtask

    task automatic set_add_reading(input logic [4:0] src, input logic use2);
        clear_id();
        id_valid_i = 1; id_wreg_i = 1; id_waddr_i = 5'd9; id_aluop_i = 5'd1;
        id_raddr2_i = src; id_use2_i = use2; id_pc_i = 32'h204;
        id_rdata1_i = 32'h11; id_rdata2_i = 32'h22;
    endtask

    task automatic rand_id();
        id_valid_i     = ($urandom_range(0, 7) != 0);
        id_pc_i        = $urandom;
        id_rdata1_i    = $urandom;
        id_rdata2_i    = $urandom;
        id_imm_i       = $urandom;
        id_raddr1_i    = 5'($urandom_range(0, 3));
        id_raddr2_i    = 5'($urandom_range(0, 3));
        id_use1_i      = 1'($urandom);
        id_use2_i      = 1'($urandom);
        id_waddr_i     = 5'($urandom_range(0, 3));
        id_wreg_i      = 1'($urandom);
        id_mem_read_i  = ($urandom_range(0, 2) == 0);
        id_mem_write_i = ($urandom_range(0, 4) == 0);
        id_aluop_i     = 5'($urandom);
    endtask

    initial begin
        logic [31:0] held_pc;
        int          cnt_before;

        stall_i = 0; flush_i = 0; rst = 0;
        clear_id();
        m = empty_slot(); m_cnt = 0;
        #1;
        do_reset("reset0");

        // Normal flow
        clear_id();
        id_valid_i = 1; id_pc_i = 32'h100; id_rdata1_i = 32'h5; id_imm_i = 32'h10; id_wreg_i = 1;
        step("normal");
        check("normal.pc", ex_pc_o, 32'h100);
        check("normal.rd1", ex_rdata1_o, 32'h5);
        check("normal.imm", ex_imm_o, 32'h10);
        check("normal.wreg", ex_wreg_o, 1);
        check("normal.haz", hazard_stall_o, 0);

        // Load-use: one bubble, then the dependent add enters
        set_load(5'd8);
        step("lw");
        set_add_reading(5'd8, 1'b1);
        #1;
        check("lu.stall", hazard_stall_o, 1);
        step("lu.bubble");
        check("lu.bubble_valid", ex_valid_o, 0);
        check("lu.cnt", bubble_cnt_o, 1);
        check("lu.stall_drop", hazard_stall_o, 0);
        step("lu.add");
        check("lu.add_valid", ex_valid_o, 1);
        check("lu.add_waddr", ex_waddr_o, 9);

        // use2=0 and $0 destination never stall
        set_load(5'd8);
        step("lw2");
        set_add_reading(5'd8, 1'b0);
        #1;
        check("nouse.stall", hazard_stall_o, 0);
        step("nouse.add");
        check("nouse.valid", ex_valid_o, 1);
        set_load(5'd0);
        step("lw0");
        set_add_reading(5'd0, 1'b1);
        #1;
        check("r0.stall", hazard_stall_o, 0);
        step("r0.add");

        // Flush beats hazard; flushed store does not write
        set_load(5'd8);
        step("lw3");
        set_add_reading(5'd8, 1'b1);
        flush_i = 1;
        #1;
        check("fl.stall", hazard_stall_o, 1);
        step("fl.bubble");
        check("fl.valid", ex_valid_o, 0);
        check("fl.cnt", bubble_cnt_o, 1);
        clear_id();
        id_valid_i = 1; id_mem_write_i = 1; id_pc_i = 32'h300;
        step("fl.store");
        check("fl.store_mwr", ex_mem_write_o, 0);
        flush_i = 0;

        // Stall hold with changing ID inputs
        clear_id();
        id_valid_i = 1; id_pc_i = 32'h400; id_wreg_i = 1; id_waddr_i = 5'd4;
        step("st.load");
        held_pc = 32'h400;
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step("st.hold");
            check("st.pc", ex_pc_o, held_pc);
        end
        stall_i = 0;

        // Stall during hazard defers the bubble to the first unstalled edge
        set_load(5'd8);
        step("lw4");
        set_add_reading(5'd8, 1'b1);
        cnt_before = m_cnt;
        stall_i = 1;
        for (int i = 0; i < 2; i++) begin
            step("sh.hold");
            check("sh.valid", ex_valid_o, 1);
            check("sh.cnt", bubble_cnt_o, cnt_before);
        end
        stall_i = 0;
        step("sh.bubble");
        check("sh.bubble_valid", ex_valid_o, 0);
        check("sh.cnt_inc", bubble_cnt_o, cnt_before + 1);

        // Random traffic; upstream honours hazard_stall by holding ID
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rand_id();
                do_reset("rand.reset");
            end
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            if (!model_hazard() || stall_i || flush_i) rand_id();
            step("rand");
        end
        stall_i = 0; flush_i = 0;

        // Saturation over 20 load-use pairs from a cleared counter
        clear_id();
        do_reset("sat.reset");
        for (int i = 0; i < 20; i++) begin
            set_load(5'd8);
            step("sat.lw");
            set_add_reading(5'd8, 1'b1);
            step("sat.bubble");
            step("sat.add");
            if (i == 15) check("sat.at16", bubble_cnt_o, CNT_MAX);
        end
        check("sat.final", bubble_cnt_o, CNT_MAX);

        // Asynchronous reset mid-hazard
        set_load(5'd8);
        step("lw5");
        set_add_reading(5'd8, 1'b1);
        #2;
        check("ar.pre_stall", hazard_stall_o, 1);
        rst = 1'b1;
        #1;
        check("ar.stall", hazard_stall_o, 0);
        check("ar.valid", ex_valid_o, 0);
        check("ar.cnt", bubble_cnt_o, 0);
        m = empty_slot(); m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
